l2_bank_ctrl: RTL and testbench
===============================

L2_BANK_CTRL -- requirements
Module: l2_bank_ctrl

Interface
REQ-001 Parameter ID_WIDTH, default 20, width of the initiator ID carried with each request.
REQ-002 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 Parameter DATA_WIDTH, default 64, data width; BE_WIDTH = DATA_WIDTH/8, ADDR_LSB = log2(BE_WIDTH).
REQ-004 Parameter MEM_ADDR_WIDTH, default 12, SRAM word address width.
REQ-005 Parameter RESP_DEPTH, default 3, minimum 2, response FIFO entries.
REQ-006 clk  input  1  clock; all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 data_req_i  input  1  request from upstream 2:1 arbiter.
REQ-009 data_add_i  input  ADDR_WIDTH  byte address.
REQ-010 data_wen_i  input  1  1 = read, 0 = write.
REQ-011 data_wdata_i  input  DATA_WIDTH  write data.
REQ-012 data_be_i  input  BE_WIDTH  byte enables, active-high.
REQ-013 data_ID_i  input  ID_WIDTH  initiator ID.
REQ-014 data_gnt_o  output  1  request accepted this cycle.
REQ-015 data_r_valid_o  output  1  response valid.
REQ-016 data_r_rdata_o  output  DATA_WIDTH  read data (write responses carry the captured SRAM output, content don't-care).
REQ-017 data_r_ID_o  output  ID_WIDTH  ID of the request being answered.
REQ-018 data_r_ready_i  input  1  downstream consumes response when high with valid.
REQ-019 mem_csn_o  output  1  SRAM chip select, active-low.
REQ-020 mem_wen_o  output  1  SRAM write enable, active-low.
REQ-021 mem_add_o  output  MEM_ADDR_WIDTH  data_add_i[MEM_ADDR_WIDTH+ADDR_LSB-1:ADDR_LSB].
REQ-022 mem_wdata_o  output  DATA_WIDTH  data_wdata_i pass-through.
REQ-023 mem_be_o  output  BE_WIDTH  data_be_i pass-through.
REQ-024 mem_rdata_i  input  DATA_WIDTH  SRAM read data, valid exactly one cycle after a read access.

Function
REQ-025 Accept = data_req_i & data_gnt_o; data_gnt_o = data_req_i & (occ + inflight < RESP_DEPTH), occ and inflight taken from registers at cycle start.
REQ-026 data_gnt_o shall have no combinational path from data_r_ready_i or mem_rdata_i.
REQ-027 mem_csn_o = ~accept; mem_wen_o = data_wen_i when accepted, 1 otherwise; SRAM is never accessed without a grant.
REQ-028 On accept, inflight register sets to 1 and stores data_ID_i; cleared next cycle unless another accept occurs.
REQ-029 One cycle after accept, {mem_rdata_i, stored ID} is pushed into the response FIFO; every accepted request (read or write) produces exactly one response.
REQ-030 data_r_valid_o = FIFO not empty; data_r_rdata_o/data_r_ID_o = FIFO head; pop on data_r_valid_o & data_r_ready_i.
REQ-031 Head outputs shall hold stable while data_r_valid_o=1 and data_r_ready_i=0.
REQ-032 Simultaneous push and pop on a full or empty FIFO: occupancy unchanged, order preserved (FIFO never bypassed; response latency minimum 2 cycles after accept).
REQ-033 FIFO pointers wrap modulo RESP_DEPTH; occ counter width ceil(log2(RESP_DEPTH+1)).
REQ-034 Responses returned strictly in acceptance order.
REQ-035 With RESP_DEPTH=3 and data_r_ready_i held 1, sustained throughput shall be one grant per cycle.
REQ-036 Overflow impossible by REQ-025; push to a full FIFO is a design error flagged by assertion.

Reset
REQ-037 While rst_n=0: data_gnt_o=0, data_r_valid_o=0, mem_csn_o=1, mem_wen_o=1, occ=0, pointers=0, inflight=0; data_r_rdata_o/data_r_ID_o reset to 0.
REQ-038 Reset mid-operation discards in-flight and queued responses; no response emitted for them after reset release.

Verification
REQ-039 Single read addr 0x0000_0018, ID 0x5, r_ready=1 -> gnt same cycle, mem_add_o=0x003, mem_csn_o=0, mem_wen_o=1; r_valid 2 cycles later with SRAM data, r_ID=0x5.
REQ-040 Write addr 0x40, be 0x0F, ID 0x9 -> mem_wen_o=0, mem_be_o=0x0F, mem_add_o=0x008; one response with r_ID=0x9.
REQ-041 Back-to-back reads IDs 1..8, r_ready=1 -> gnt every cycle, responses IDs 1..8 in order on consecutive cycles.
REQ-042 r_ready=0, continuous requests -> exactly 3 grants then gnt=0; raise r_ready -> responses 1,2,3 in order, grants resume.
REQ-043 Alternating r_ready (1,0,1,0...) with random requests -> no lost/duplicated/reordered IDs, head stable while stalled.
REQ-044 Assert rst_n=0 with 2 queued responses and 1 in flight -> r_valid=0 immediately; after release no stale responses, first new request answered normally.

Source files
------------

// File: rtl/l2_bank_ctrl.sv
// L2 bank controller: grants requests onto a 1-cycle SRAM and returns one
// response per accepted request, in order, through a small response FIFO.
module l2_bank_ctrl #(
   parameter int ID_WIDTH       = 20,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int MEM_ADDR_WIDTH = 12,
   parameter int RESP_DEPTH     = 3,
   localparam int BE_WIDTH      = DATA_WIDTH / 8,
   localparam int ADDR_LSB      = $clog2(BE_WIDTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      data_req_i,
   input  logic [ADDR_WIDTH-1:0]     data_add_i,
   input  logic                      data_wen_i,
   input  logic [DATA_WIDTH-1:0]     data_wdata_i,
   input  logic [BE_WIDTH-1:0]       data_be_i,
   input  logic [ID_WIDTH-1:0]       data_ID_i,
   output logic                      data_gnt_o,
   output logic                      data_r_valid_o,
   output logic [DATA_WIDTH-1:0]     data_r_rdata_o,
   output logic [ID_WIDTH-1:0]       data_r_ID_o,
   input  logic                      data_r_ready_i,
   output logic                      mem_csn_o,
   output logic                      mem_wen_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_add_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   output logic [BE_WIDTH-1:0]       mem_be_o,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

   localparam int PTR_W = $clog2(RESP_DEPTH);
   localparam int OCC_W = $clog2(RESP_DEPTH + 1);

   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]      occ_q;
   logic                  inflight_q;
   logic [ID_WIDTH-1:0]   inflight_id_q;
   logic [DATA_WIDTH-1:0] rdata_q [RESP_DEPTH];
   logic [ID_WIDTH-1:0]   id_q    [RESP_DEPTH];
   logic [OCC_W:0]        level;
   logic                  accept, push, pop;
   logic                  unused_add;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Grant depends only on registered state, reserving a slot for the in-flight access.
   assign level      = {1'b0, occ_q} + (OCC_W + 1)'(inflight_q);
   assign data_gnt_o = data_req_i & rst_n & (level < (OCC_W + 1)'(RESP_DEPTH));
   assign accept     = data_gnt_o;
   assign push       = inflight_q;
   assign pop        = data_r_valid_o & data_r_ready_i;

   assign mem_csn_o   = ~accept;
   assign mem_wen_o   = accept ? data_wen_i : 1'b1;
   assign mem_add_o   = data_add_i[MEM_ADDR_WIDTH+ADDR_LSB-1:ADDR_LSB];
   assign mem_wdata_o = data_wdata_i;
   assign mem_be_o    = data_be_i;
   assign unused_add  = ^data_add_i;

   assign data_r_valid_o = (occ_q != '0);
   assign data_r_rdata_o = rdata_q[rd_ptr_q];
   assign data_r_ID_o    = id_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q    <= 1'b0;
         inflight_id_q <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         occ_q         <= '0;
         for (int unsigned i = 0; i < RESP_DEPTH; i++) begin
            rdata_q[i] <= '0;
            id_q[i]    <= '0;
         end
      end else begin
         inflight_q <= accept;
         if (accept) inflight_id_q <= data_ID_i;
         if (push) begin
            rdata_q[wr_ptr_q] <= mem_rdata_i;
            id_q[wr_ptr_q]    <= inflight_id_q;
            wr_ptr_q          <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   occ_q <= occ_q + 1'b1;
            2'b01:   occ_q <= occ_q - 1'b1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (occ_q != OCC_W'(RESP_DEPTH)) || pop);

endmodule

// File: tb/tb_l2_bank_ctrl.sv
// Directed self-checking bench for l2_bank_ctrl with a 1-cycle SRAM model.
module tb_l2_bank_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        data_req_i;
   logic [31:0] data_add_i;
   logic        data_wen_i;
   logic [63:0] data_wdata_i;
   logic [7:0]  data_be_i;
   logic [19:0] data_ID_i;
   logic        data_gnt_o;
   logic        data_r_valid_o;
   logic [63:0] data_r_rdata_o;
   logic [19:0] data_r_ID_o;
   logic        data_r_ready_i;
   logic        mem_csn_o;
   logic        mem_wen_o;
   logic [11:0] mem_add_o;
   logic [63:0] mem_wdata_o;
   logic [7:0]  mem_be_o;
   logic [63:0] mem_rdata_i;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   l2_bank_ctrl #(.ID_WIDTH(20), .ADDR_WIDTH(32), .DATA_WIDTH(64),
                  .MEM_ADDR_WIDTH(12), .RESP_DEPTH(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
      .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_ID_i(data_ID_i),
      .data_gnt_o(data_gnt_o), .data_r_valid_o(data_r_valid_o),
      .data_r_rdata_o(data_r_rdata_o), .data_r_ID_o(data_r_ID_o),
      .data_r_ready_i(data_r_ready_i),
      .mem_csn_o(mem_csn_o), .mem_wen_o(mem_wen_o), .mem_add_o(mem_add_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
   );

   function automatic logic [63:0] pattern(input logic [11:0] w);
      return {16'hDEAD, 4'h0, w, 16'hBEEF, 4'h0, w};
   endfunction

   // SRAM: preloaded with pattern(), byte-enabled writes, read data one cycle later
   logic [63:0] sram [4096];
   logic        sram_init;
   always @(posedge clk) begin
      if (sram_init !== 1'b1) begin
         for (int i = 0; i < 4096; i++) sram[i] <= pattern(12'(i));
         sram_init <= 1'b1;
      end else if (!mem_csn_o) begin
         if (!mem_wen_o) begin
            for (int b = 0; b < 8; b++)
               if (mem_be_o[b]) sram[mem_add_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         end
         mem_rdata_i <= sram[mem_add_o];
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic req, input logic [31:0] addr, input logic wen,
                        input logic [63:0] wdata, input logic [7:0] be, input logic [19:0] id);
      data_req_i   = req;
      data_add_i   = addr;
      data_wen_i   = wen;
      data_wdata_i = wdata;
      data_be_i    = be;
      data_ID_i    = id;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b1, 64'h0, 8'h00, 20'h0);
   endtask

   int          exp_gnt  [0:7]  = '{1, 1, 1, 0, 0, 0, 0, 1};
   int          exp_head [0:10] = '{0, 0, 1, 1, 1, 1, 1, 2, 3, 4, 0};
   int unsigned exp_q [$];
   int unsigned next_id, exp_id;
   logic        stalled;
   logic [19:0] stall_id;
   logic [63:0] stall_data;

   initial begin
      rst_n = 1'b0;
      data_r_ready_i = 1'b1;
      drive(1'b1, 32'h18, 1'b1, 64'h0, 8'hFF, 20'h5);
      tick(); tick(); #4;
      check("rst_gnt",   64'(data_gnt_o), 64'h0);
      check("rst_valid", 64'(data_r_valid_o), 64'h0);
      check("rst_csn",   64'(mem_csn_o), 64'h1);
      check("rst_wen",   64'(mem_wen_o), 64'h1);
      check("rst_rdata", data_r_rdata_o, 64'h0);
      check("rst_id",    64'(data_r_ID_o), 64'h0);
      tick(); rst_n = 1'b1; idle();

      // single read
      tick(); drive(1'b1, 32'h0000_0018, 1'b1, 64'h0, 8'hFF, 20'h5); #4;
      check("rd_gnt", 64'(data_gnt_o), 64'h1);
      check("rd_add", 64'(mem_add_o), 64'h003);
      check("rd_csn", 64'(mem_csn_o), 64'h0);
      check("rd_wen", 64'(mem_wen_o), 64'h1);
      tick(); idle(); #4;
      check("rd_lat", 64'(data_r_valid_o), 64'h0);
      tick(); #4;
      check("rd_valid", 64'(data_r_valid_o), 64'h1);
      check("rd_id",    64'(data_r_ID_o), 64'h5);
      check("rd_data",  data_r_rdata_o, 64'hDEAD_0003_BEEF_0003);
      tick(); #4;
      check("rd_done", 64'(data_r_valid_o), 64'h0);

      // write, then read back the merged word
      tick(); drive(1'b1, 32'h40, 1'b0, 64'h1111_2222_3333_4444, 8'h0F, 20'h9); #4;
      check("wr_gnt",   64'(data_gnt_o), 64'h1);
      check("wr_wen",   64'(mem_wen_o), 64'h0);
      check("wr_be",    64'(mem_be_o), 64'h0F);
      check("wr_add",   64'(mem_add_o), 64'h008);
      check("wr_wdata", mem_wdata_o, 64'h1111_2222_3333_4444);
      tick(); idle();
      tick(); #4;
      check("wr_valid", 64'(data_r_valid_o), 64'h1);
      check("wr_id",    64'(data_r_ID_o), 64'h9);
      tick(); #4;
      check("wr_done", 64'(data_r_valid_o), 64'h0);
      tick(); drive(1'b1, 32'h40, 1'b1, 64'h0, 8'hFF, 20'hA); #4;
      check("rb_gnt", 64'(data_gnt_o), 64'h1);
      tick(); idle();
      tick(); #4;
      check("rb_id",   64'(data_r_ID_o), 64'hA);
      check("rb_data", data_r_rdata_o, 64'hDEAD_0008_3333_4444);
      tick(); #4;
      check("rb_done", 64'(data_r_valid_o), 64'h0);

      // back-to-back reads IDs 1..8
      for (int k = 0; k < 11; k++) begin
         tick();
         if (k < 8) drive(1'b1, 32'(k * 8), 1'b1, 64'h0, 8'hFF, 20'(k + 1));
         else idle();
         #4;
         if (k < 8) check("b2b_gnt", 64'(data_gnt_o), 64'h1);
         if (k >= 2 && k < 10) begin
            check("b2b_valid", 64'(data_r_valid_o), 64'h1);
            check("b2b_id",    64'(data_r_ID_o), 64'(k - 1));
            check("b2b_data",  data_r_rdata_o, pattern(12'(k - 2)));
         end else begin
            check("b2b_idle", 64'(data_r_valid_o), 64'h0);
         end
      end

      // backpressure: three grants then stall, release drains in order
      for (int k = 0; k < 11; k++) begin
         tick();
         data_r_ready_i = (k >= 6);
         if (k < 8) drive(1'b1, 32'((k < 3 ? k + 1 : 4) * 8), 1'b1, 64'h0, 8'hFF, 20'(k < 3 ? k + 1 : 4));
         else idle();
         #4;
         if (k < 8) begin
            check("bp_gnt", 64'(data_gnt_o), 64'(exp_gnt[k]));
            check("bp_csn", 64'(mem_csn_o), 64'(exp_gnt[k] == 0));
         end
         check("bp_valid", 64'(data_r_valid_o), 64'(exp_head[k] != 0));
         if (exp_head[k] != 0) check("bp_head", 64'(data_r_ID_o), 64'(exp_head[k]));
      end

      // alternating ready with random requests
      next_id = 32'h100;
      stalled = 1'b0;
      for (int k = 0; k < 48; k++) begin
         tick();
         data_r_ready_i = (k % 2 == 0) || (k >= 40);
         if (k < 40) drive(1'($urandom_range(0, 1)), next_id * 8, 1'b1, 64'h0, 8'hFF, 20'(next_id));
         else idle();
         #4;
         if (stalled && data_r_valid_o) begin
            check("alt_hold_id",   64'(data_r_ID_o), 64'(stall_id));
            check("alt_hold_data", data_r_rdata_o, stall_data);
         end
         stalled = 1'b0;
         if (data_gnt_o) begin
            exp_q.push_back(next_id);
            next_id++;
         end
         if (data_r_valid_o && data_r_ready_i) begin
            if (exp_q.size() == 0) check("alt_spurious", 64'h1, 64'h0);
            else begin
               exp_id = exp_q.pop_front();
               check("alt_id",   64'(data_r_ID_o), 64'(exp_id));
               check("alt_data", data_r_rdata_o, pattern(12'(exp_id)));
            end
         end else if (data_r_valid_o) begin
            stalled    = 1'b1;
            stall_id   = data_r_ID_o;
            stall_data = data_r_rdata_o;
         end
      end
      check("alt_drained", 64'(exp_q.size()), 64'h0);
      check("alt_idle",    64'(data_r_valid_o), 64'h0);

      // reset with two queued and one in flight
      data_r_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(); drive(1'b1, 32'((k + 1) * 8), 1'b1, 64'h0, 8'hFF, 20'(32'h21 + k)); #4;
         check("mr_gnt", 64'(data_gnt_o), 64'h1);
      end
      tick();
      rst_n = 1'b0;
      drive(1'b1, 32'h0, 1'b1, 64'h0, 8'hFF, 20'h77);
      #4;
      check("mr_valid", 64'(data_r_valid_o), 64'h0);
      check("mr_gnt0",  64'(data_gnt_o), 64'h0);
      check("mr_csn",   64'(mem_csn_o), 64'h1);
      tick(); tick();
      rst_n = 1'b1;
      idle();
      data_r_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #4; check("mr_stale", 64'(data_r_valid_o), 64'h0);
         tick();
      end
      drive(1'b1, 32'h28, 1'b1, 64'h0, 8'hFF, 20'h3C); #4;
      check("mr_new_gnt", 64'(data_gnt_o), 64'h1);
      tick(); idle();
      tick(); #4;
      check("mr_new_valid", 64'(data_r_valid_o), 64'h1);
      check("mr_new_id",    64'(data_r_ID_o), 64'h3C);
      check("mr_new_data",  data_r_rdata_o, 64'hDEAD_0005_BEEF_0005);
      tick(); #4;
      check("mr_new_done", 64'(data_r_valid_o), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
